mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Arbitrates memory requests from NUM_CORES cores onto one shared memory port; routes responses back by source.
//  Sits directly downstream of each core's mem_req/mem_rsp interface (core-side load/store traffic) and upstream of memory.
//  Round-robin grant, one-entry registered output stage, per-core outstanding-request limit.
// PARAMETERS
//  NUM_CORES        4    requesting cores
//  ADDR_W           32   address width
//  DATA_W           64   data width
//  TAG_W            6    per-core transaction tag (64 outstanding ids)
//  MAX_OUTSTANDING  64   max un-responded requests per core
// PORTS
//  clk            in   1                  core clock
//  reset          in   1                  asynchronous, active-low reset
//  req_vld        in   NUM_CORES          per-core request valid
//  req_we         in   NUM_CORES          1=write, 0=read
//  req_addr       in   NUM_CORES*ADDR_W   per-core address, core i at [i*ADDR_W +: ADDR_W]
//  req_data       in   NUM_CORES*DATA_W   per-core write data
//  req_tag        in   NUM_CORES*TAG_W    per-core tag
//  req_rdy        out  NUM_CORES          one-hot grant; request accepted when req_vld[i]&req_rdy[i]
//  mem_req_vld    out  1                  request to memory valid
//  mem_req_we/addr/data/tag out 1/ADDR_W/DATA_W/TAG_W  granted request fields
//  mem_req_src    out  $clog2(NUM_CORES)  originating core index
//  mem_req_rdy    in   1                  memory accepts when mem_req_vld&mem_req_rdy
//  mem_rsp_vld    in   1                  memory response valid (no backpressure)
//  mem_rsp_src    in   $clog2(NUM_CORES)  destination core
//  mem_rsp_tag/data in TAG_W/DATA_W       response tag, read data (write ack: data don't-care)
//  rsp_vld        out  NUM_CORES          one-hot response valid to core
//  rsp_tag/rsp_data out TAG_W/DATA_W      shared response fields, qualified by rsp_vld
//  err_stray      out  1                  sticky: response arrived for core with 0 outstanding
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, rr pointer=0, outstanding counters=0, output stage empty, err_stray=0.
//  Output stage: slot "free" when !mem_req_vld or (mem_req_vld&mem_req_rdy) this cycle.
//  Eligible core i: req_vld[i] & outstanding[i] < MAX_OUTSTANDING.
//  req_rdy is combinational: at most one bit set, only when slot free; picks first eligible core at/after rr_ptr (wrap mod NUM_CORES).
//  On accept of core g: slot loads fields next edge, mem_req_src=g, rr_ptr <= (g+1)%NUM_CORES; no accept -> rr_ptr holds.
//  Latency: accept at edge N -> mem_req_vld=1 after edge N; back-to-back 1 req/cycle while mem_req_rdy=1.
//  mem_req_rdy=0: slot fields held stable, mem_req_vld stays 1, all req_rdy=0.
//  Slot drained with no new accept -> mem_req_vld=0 next cycle.
//  Every request (read and write) expects exactly one response.
//  outstanding[i] +1 on accept from core i, -1 on rsp delivered to core i; both same cycle -> unchanged.
//  Counter width $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING (gated by eligibility).
//  Response path: registered, 1 cycle: mem_rsp_vld at edge N -> rsp_vld[mem_rsp_src]=1, rsp_tag/rsp_data after N.
//  rsp_vld is a pulse per response; consecutive responses back-to-back allowed.
//  Stray response (outstanding[src]==0): not delivered (rsp_vld stays 0), counter unchanged, err_stray<=1 until reset.
//  mem_rsp_src >= NUM_CORES treated as stray.
//  Reset mid-operation: in-flight slot and counters discarded; no output pulses after reset asserts.
// TESTING
//  1 Single core 0 read addr=0x100 tag=5, mem_req_rdy=1 -> mem_req_vld next cycle, src=0, addr=0x100, tag=5; outstanding[0]=1.
//  2 All 4 cores req_vld=1 continuously, mem_req_rdy=1 -> grants 0,1,2,3,0,... one per cycle.
//  3 Slot full, mem_req_rdy=0 for 5 cycles -> mem_req fields stable, req_rdy=0; rdy=1 -> drain and new grant same cycle.
//  4 Core 2 issues 64 reads with no responses -> 65th not granted (req_rdy[2]=0); one rsp to src=2 -> grant resumes next cycle.
//  5 mem_rsp_vld src=1 tag=9 data=0xDEAD -> next cycle rsp_vld=0b0010, rsp_tag=9, rsp_data=0xDEAD; outstanding[1] decrements.
//  6 Response to src=3 with outstanding[3]=0 -> rsp_vld=0, err_stray=1 held; assert reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter from NUM_CORES cores onto one memory port, with a
// registered request slot, per-core outstanding limits and response routing.
module mem_req_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int TAG_W           = 6,
    parameter int MAX_OUTSTANDING = 64,
    localparam int SRC_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_vld,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_data,
    input  logic [NUM_CORES*TAG_W-1:0]  req_tag,
    output logic [NUM_CORES-1:0]        req_rdy,
    output logic                        mem_req_vld,
    output logic                        mem_req_we,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic [DATA_W-1:0]           mem_req_data,
    output logic [TAG_W-1:0]            mem_req_tag,
    output logic [SRC_W-1:0]            mem_req_src,
    input  logic                        mem_req_rdy,
    input  logic                        mem_rsp_vld,
    input  logic [SRC_W-1:0]            mem_rsp_src,
    input  logic [TAG_W-1:0]            mem_rsp_tag,
    input  logic [DATA_W-1:0]           mem_rsp_data,
    output logic [NUM_CORES-1:0]        rsp_vld,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        err_stray
);

    logic                 slot_free;
    logic                 found;
    logic                 accept;
    logic                 src_ok;
    logic                 rsp_ok;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     gnt_idx;
    logic [SRC_W-1:0]     idx;
    logic [SRC_W-1:0]     rr_next;
    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] inc_v;
    logic [NUM_CORES-1:0] dec_v;
    logic [CNT_W-1:0]     outstanding [NUM_CORES];

    assign slot_free = !mem_req_vld || mem_req_rdy;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            elig[i] = req_vld[i] &&
                      (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // Scan starts at rr_ptr; first eligible core wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_CORES);
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign accept  = found && slot_free && reset;
    assign rr_next = SRC_W'((int'(gnt_idx) + 1) % NUM_CORES);

    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[gnt_idx] = 1'b1;
    end

    generate
        if ((1 << SRC_W) > NUM_CORES) begin : g_src_chk
            assign src_ok = mem_rsp_src < SRC_W'(NUM_CORES);
        end else begin : g_src_all
            assign src_ok = 1'b1;
        end
    endgenerate

    assign rsp_ok = mem_rsp_vld && src_ok &&
                    (outstanding[mem_rsp_src] != '0);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            inc_v[i] = accept && (gnt_idx == SRC_W'(i));
            dec_v[i] = rsp_ok && (mem_rsp_src == SRC_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_vld  <= 1'b0;
            mem_req_we   <= 1'b0;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            mem_req_tag  <= '0;
            mem_req_src  <= '0;
            rr_ptr       <= '0;
        end else if (accept) begin
            mem_req_vld  <= 1'b1;
            mem_req_we   <= req_we[gnt_idx];
            mem_req_addr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            mem_req_data <= req_data[gnt_idx*DATA_W +: DATA_W];
            mem_req_tag  <= req_tag[gnt_idx*TAG_W +: TAG_W];
            mem_req_src  <= gnt_idx;
            rr_ptr       <= rr_next;
        end else if (mem_req_rdy) begin
            mem_req_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (inc_v[i] && !dec_v[i])
                    outstanding[i] <= outstanding[i] + CNT_W'(1);
                else if (dec_v[i] && !inc_v[i])
                    outstanding[i] <= outstanding[i] - CNT_W'(1);
            end
        end
    end

    // dec_v is already the one-hot delivery mask of a non-stray response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld   <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
            err_stray <= 1'b0;
        end else begin
            rsp_vld <= dec_v;
            if (rsp_ok) begin
                rsp_tag  <= mem_rsp_tag;
                rsp_data <= mem_rsp_data;
            end
            if (mem_rsp_vld && !rsp_ok) err_stray <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: grant table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_req_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int TW   = 6;
    localparam int MAXO = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_rdy;
    logic            mem_req_vld;
    logic            mem_req_we;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic [TW-1:0]   mem_req_tag;
    logic [1:0]      mem_req_src;
    logic            mem_req_rdy;
    logic            mem_rsp_vld;
    logic [1:0]      mem_rsp_src;
    logic [TW-1:0]   mem_rsp_tag;
    logic [DW-1:0]   mem_rsp_data;
    logic [N-1:0]    rsp_vld;
    logic [TW-1:0]   rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic            err_stray;

    int nchk = 0;
    int nfail = 0;

    mem_req_arbiter dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_we(req_we), .req_addr(req_addr),
        .req_data(req_data), .req_tag(req_tag), .req_rdy(req_rdy),
        .mem_req_vld(mem_req_vld), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_tag(mem_req_tag), .mem_req_src(mem_req_src),
        .mem_req_rdy(mem_req_rdy), .mem_rsp_vld(mem_rsp_vld),
        .mem_rsp_src(mem_rsp_src), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_data(mem_rsp_data), .rsp_vld(rsp_vld),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] exp_rdy;
        int           exp_src;
    } vec_t;

    // Reference model state
    int           m_outs [N];
    int           m_rr;
    bit           m_vld;
    bit           m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    int           m_src;
    logic [N-1:0] m_rsp_vld;
    logic [TW-1:0] m_rsp_tag;
    logic [DW-1:0] m_rsp_data;
    bit           m_err;
    logic [TW-1:0] pend [N][$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_vld     = '0;
        req_we      = '0;
        req_addr    = '0;
        req_data    = '0;
        req_tag     = '0;
        mem_req_rdy = 1'b1;
        mem_rsp_vld = 1'b0;
        mem_rsp_src = '0;
        mem_rsp_tag = '0;
        mem_rsp_data = '0;
    endtask

    task automatic set_req(input int c, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_we[c]           = we;
        req_addr[c*AW +: AW] = a;
        req_data[c*DW +: DW] = d;
        req_tag[c*TW +: TW]  = t;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_outs[i] = 0;
            pend[i].delete();
        end
        m_rr = 0; m_vld = 0; m_we = 0; m_addr = '0; m_data = '0;
        m_tag = '0; m_src = 0; m_rsp_vld = '0; m_rsp_tag = '0;
        m_rsp_data = '0; m_err = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    function automatic int pick();
        if (m_vld && !mem_req_rdy) return -1;
        for (int k = 0; k < N; k++) begin
            int c = (m_rr + k) % N;
            if (req_vld[c] && m_outs[c] < MAXO) return c;
        end
        return -1;
    endfunction

    // Applies one clock edge to the model; inputs are still the pre-edge ones.
    task automatic model_edge(input int g);
        int  s = int'(mem_rsp_src);
        bit  ok = mem_rsp_vld && s < N && m_outs[s] > 0;
        m_rsp_vld = '0;
        if (ok) begin
            m_rsp_vld  = N'(1) << s;
            m_rsp_tag  = mem_rsp_tag;
            m_rsp_data = mem_rsp_data;
            m_outs[s]--;
        end else if (mem_rsp_vld) begin
            m_err = 1;
        end
        if (g >= 0) begin
            m_vld  = 1;
            m_we   = req_we[g];
            m_addr = req_addr[g*AW +: AW];
            m_data = req_data[g*DW +: DW];
            m_tag  = req_tag[g*TW +: TW];
            m_src  = g;
            m_rr   = (g + 1) % N;
            m_outs[g]++;
            pend[g].push_back(req_tag[g*TW +: TW]);
        end else if (mem_req_rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic compare_model();
        check("rnd mem_req_vld", mem_req_vld, m_vld);
        if (m_vld) begin
            check("rnd mem_req_src", mem_req_src, m_src);
            check("rnd mem_req_addr", mem_req_addr, m_addr);
            check("rnd mem_req_data", mem_req_data, m_data);
            check("rnd mem_req_tag", mem_req_tag, m_tag);
            check("rnd mem_req_we", mem_req_we, m_we);
        end
        check("rnd rsp_vld", rsp_vld, m_rsp_vld);
        if (m_rsp_vld != 0) begin
            check("rnd rsp_tag", rsp_tag, m_rsp_tag);
            check("rnd rsp_data", rsp_data, m_rsp_data);
        end
        check("rnd err_stray", err_stray, m_err);
    endtask

    initial begin
        vec_t vt [10];
        int   sat_cycles = 0;

        vt[0] = '{4'b1111, 4'b0001, 0};
        vt[1] = '{4'b1111, 4'b0010, 1};
        vt[2] = '{4'b0001, 4'b0001, 0};
        vt[3] = '{4'b1001, 4'b1000, 3};
        vt[4] = '{4'b0110, 4'b0010, 1};
        vt[5] = '{4'b0000, 4'b0000, 0};
        vt[6] = '{4'b0011, 4'b0001, 0};
        vt[7] = '{4'b0100, 4'b0100, 2};
        vt[8] = '{4'b1111, 4'b1000, 3};
        vt[9] = '{4'b1010, 4'b0010, 1};

        // Reset state
        do_reset();
        check("reset mem_req_vld", mem_req_vld, 0);
        check("reset rsp_vld", rsp_vld, 0);
        check("reset err_stray", err_stray, 0);
        check("reset req_rdy", req_rdy, 0);

        // Round-robin grant table
        for (int c = 0; c < N; c++) set_req(c, 0, 32'h1000 + c, 0, TW'(c));
        for (int i = 0; i < 10; i++) begin
            req_vld = vt[i].vld;
            #1;
            check($sformatf("tbl%0d req_rdy", i), req_rdy, vt[i].exp_rdy);
            tick();
            check($sformatf("tbl%0d mem_req_vld", i), mem_req_vld,
                  vt[i].exp_rdy != 0);
            if (vt[i].exp_rdy != 0) begin
                check($sformatf("tbl%0d src", i), mem_req_src, vt[i].exp_src);
                check($sformatf("tbl%0d addr", i), mem_req_addr,
                      32'h1000 + vt[i].exp_src);
            end
        end

        // Single read from core 0, then its response is delivered
        do_reset();
        set_req(0, 0, 32'h100, 64'h0, 6'd5);
        req_vld = 4'b0001;
        #1;
        check("t1 req_rdy", req_rdy, 4'b0001);
        tick();
        req_vld = '0;
        check("t1 mem_req_vld", mem_req_vld, 1);
        check("t1 src", mem_req_src, 0);
        check("t1 addr", mem_req_addr, 32'h100);
        check("t1 tag", mem_req_tag, 5);
        check("t1 we", mem_req_we, 0);
        mem_rsp_vld = 1; mem_rsp_src = 0; mem_rsp_tag = 5;
        mem_rsp_data = 64'h1234;
        tick();
        mem_rsp_vld = 0;
        check("t1 drained", mem_req_vld, 0);
        check("t1 rsp_vld", rsp_vld, 4'b0001);
        check("t1 rsp_data", rsp_data, 64'h1234);
        check("t1 no stray", err_stray, 0);

        // Backpressure: slot held stable, then drain and grant same cycle
        do_reset();
        mem_req_rdy = 0;
        set_req(1, 1, 32'hA0, 64'h55, 6'd3);
        req_vld = 4'b0010;
        #1;
        check("t3 first rdy", req_rdy, 4'b0010);
        tick();
        req_vld = 4'b1111;
        for (int c = 0; c < N; c++) set_req(c, 0, 32'hFFFF, 64'h0, 6'd0);
        set_req(2, 0, 32'h200, 64'h0, 6'd7);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3 stall rdy", req_rdy, 0);
            check("t3 stall vld", mem_req_vld, 1);
            check("t3 stall addr", mem_req_addr, 32'hA0);
            check("t3 stall tag", mem_req_tag, 3);
            tick();
        end
        mem_req_rdy = 1;
        #1;
        check("t3 resume rdy", req_rdy, 4'b0100);
        tick();
        req_vld = '0;
        check("t3 new src", mem_req_src, 2);
        check("t3 new addr", mem_req_addr, 32'h200);

        // Outstanding limit on core 2
        do_reset();
        req_vld = 4'b0100;
        for (int i = 0; i < MAXO; i++) begin
            set_req(2, 0, 32'(i), 64'h0, TW'(i));
            #1;
            check("t4 grant", req_rdy, 4'b0100);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4 blocked", req_rdy, 0);
            tick();
        end
        mem_rsp_vld = 1; mem_rsp_src = 2; mem_rsp_tag = 0;
        #1;
        check("t4 still blocked", req_rdy, 0);
        tick();
        mem_rsp_vld = 0;
        #1;
        check("t4 resume", req_rdy, 4'b0100);
        check("t4 rsp_vld", rsp_vld, 4'b0100);
        tick();
        req_vld = '0;

        // Response routing to core 1, then a second one is stray
        do_reset();
        set_req(1, 0, 32'h40, 64'h0, 6'd9);
        req_vld = 4'b0010;
        tick();
        req_vld = '0;
        mem_rsp_vld = 1; mem_rsp_src = 1; mem_rsp_tag = 9;
        mem_rsp_data = 64'hDEAD;
        tick();
        mem_rsp_vld = 0;
        check("t5 rsp_vld", rsp_vld, 4'b0010);
        check("t5 rsp_tag", rsp_tag, 9);
        check("t5 rsp_data", rsp_data, 64'hDEAD);
        check("t5 no stray", err_stray, 0);
        tick();
        check("t5 pulse", rsp_vld, 0);
        mem_rsp_vld = 1;
        tick();
        mem_rsp_vld = 0;
        check("t5 decremented", rsp_vld, 0);
        check("t5 stray", err_stray, 1);

        // Stray to core 3, sticky error, then reset mid-burst
        do_reset();
        mem_rsp_vld = 1; mem_rsp_src = 3; mem_rsp_tag = 1;
        tick();
        mem_rsp_vld = 0;
        check("t6 stray rsp_vld", rsp_vld, 0);
        check("t6 err_stray", err_stray, 1);
        tick();
        tick();
        check("t6 err sticky", err_stray, 1);
        req_vld = 4'b1111;
        tick();
        tick();
        mem_rsp_vld = 1; mem_rsp_src = 0; mem_rsp_tag = 2;
        tick();
        check("t6 pulse before reset", rsp_vld, 4'b0001);
        reset = 1'b0;
        #1;
        check("t6 rst mem_req_vld", mem_req_vld, 0);
        check("t6 rst req_rdy", req_rdy, 0);
        check("t6 rst rsp_vld", rsp_vld, 0);
        check("t6 rst err_stray", err_stray, 0);
        tick();
        check("t6 rst held", {mem_req_vld, rsp_vld, req_rdy}, 0);

        // Randomized traffic vs reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int g;
            int r;
            req_vld = N'($urandom);
            for (int c = 0; c < N; c++)
                set_req(c, 1'($urandom), $urandom,
                        {$urandom, $urandom}, TW'($urandom));
            mem_req_rdy = ($urandom_range(0, 9) < 7);
            mem_rsp_vld = 0;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                int c0 = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++) begin
                    int c = (c0 + k) % N;
                    if (!mem_rsp_vld && pend[c].size() > 0) begin
                        mem_rsp_vld  = 1;
                        mem_rsp_src  = 2'(c);
                        mem_rsp_tag  = pend[c].pop_front();
                        mem_rsp_data = {$urandom, $urandom};
                    end
                end
            end else if (r == 99) begin
                int c = $urandom_range(0, N - 1);
                if (m_outs[c] == 0) begin
                    mem_rsp_vld  = 1;
                    mem_rsp_src  = 2'(c);
                    mem_rsp_tag  = TW'($urandom);
                end
            end
            #1;
            g = pick();
            check("rnd req_rdy", req_rdy, (g >= 0) ? (N'(1) << g) : '0);
            for (int c = 0; c < N; c++)
                if (m_outs[c] == MAXO) sat_cycles++;
            tick();
            model_edge(g);
            compare_model();
        end
        check("rnd limit reached", sat_cycles > 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
